axi_uart_rx: RTL and testbench

- 8N1 UART receiver: 1 start bit, 8 data bits LSB first, 1 stop bit, no parity.
- Pairs with the block's existing UART transmitter on the AXI UART peripheral; feeds received bytes to the AXI-side RX data register/FIFO.
- Synchronises the asynchronous serial line, qualifies the start bit at mid-bit, samples each bit at its centre, and flags framing errors and line breaks.

---
 rtl/axi_uart_rx.sv | 138 +++++++++++++
 tb/tb_axi_uart_rx.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_uart_rx.sv
// 8N1 UART receiver: 2-FF line synchroniser, mid-bit start qualification,
// centre-of-bit sampling, framing-error and line-break detection.
`timescale 1ns/1ps
module axi_uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 347
) (
  input  logic       i_Clock,
  input  logic       i_Rst_L,
  input  logic       i_RX_Serial,
  output logic       o_RX_Active,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte,
  output logic       o_Frame_Err,
  output logic       o_Break
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT) + 1;
  localparam int unsigned HALF  = (CLKS_PER_BIT - 1) / 2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    CLEANUP = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         idx_q, idx_d;
  logic [7:0]         shift_q, shift_d;
  logic [7:0]         byte_q, byte_d;
  logic               dv_q, dv_d;
  logic               ferr_q, ferr_d;
  logic               brk_q, brk_d;
  logic               active_q, active_d;
  logic               rx_meta_q, rx_s_q;

  // Synchroniser flops reset high so reset release never looks like a start bit
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      byte_q    <= '0;
      dv_q      <= 1'b0;
      ferr_q    <= 1'b0;
      brk_q     <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      rx_meta_q <= i_RX_Serial;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      byte_q    <= byte_d;
      dv_q      <= dv_d;
      ferr_q    <= ferr_d;
      brk_q     <= brk_d;
      active_q  <= active_d;
    end
  end

  // Next-state, bit sampling and output pulse generation
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    byte_d   = byte_q;
    dv_d     = 1'b0;
    ferr_d   = 1'b0;
    brk_d    = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (!rx_s_q) state_d = START;
      end
      START: begin
        if (cnt_q == CNT_W'(HALF)) begin
          cnt_d   = '0;
          state_d = rx_s_q ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s_q;
          if (idx_q == 3'd7) begin
            idx_d   = '0;
            state_d = STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          cnt_d   = '0;
          state_d = CLEANUP;
          if (rx_s_q) begin
            byte_d = shift_q;
            dv_d   = 1'b1;
          end else begin
            ferr_d = 1'b1;
            brk_d  = (shift_q == 8'h00);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      CLEANUP: begin
        // A held-low break line parks here until the line returns high
        if (rx_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    active_d = (state_d != IDLE);
  end

  assign o_RX_Active = active_q;
  assign o_RX_DV     = dv_q;
  assign o_RX_Byte   = byte_q;
  assign o_Frame_Err = ferr_q;
  assign o_Break     = brk_q;

endmodule

// File: tb/tb_axi_uart_rx.sv
// Scoreboard bench for axi_uart_rx at 8 clocks per bit: stimulus pushes the
// expected pulse, a forked monitor pops and compares on every DV/error pulse.
`timescale 1ns/1ps
module tb_axi_uart_rx;

  localparam int  CPB    = 8;
  localparam int  HALF   = (CPB - 1) / 2;
  localparam real CLK_NS = 10.0;
  localparam real BIT_NS = CLK_NS * CPB;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic       active;
  logic       dv;
  logic [7:0] rx_byte;
  logic       ferr;
  logic       brk;

  int checks;
  int failures;
  int cyc;

  typedef struct {
    bit         is_err;
    bit         brk;
    logic [7:0] byte_v;
    int         exp_cyc;
  } exp_t;

  exp_t exp_q[$];

  axi_uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock     (clk),
    .i_Rst_L     (rst_n),
    .i_RX_Serial (rx),
    .o_RX_Active (active),
    .o_RX_DV     (dv),
    .o_RX_Byte   (rx_byte),
    .o_Frame_Err (ferr),
    .o_Break     (brk)
  );

  initial begin
    clk = 1'b0;
    forever #(CLK_NS / 2.0) clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0b required=%0b (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%02h required=%02h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic expect_dv(input logic [7:0] b, input int exp_cyc);
    exp_t e;
    e.is_err = 1'b0; e.brk = 1'b0; e.byte_v = b; e.exp_cyc = exp_cyc;
    exp_q.push_back(e);
  endtask

  task automatic expect_err(input bit is_brk, input logic [7:0] held);
    exp_t e;
    e.is_err = 1'b1; e.brk = is_brk; e.byte_v = held; e.exp_cyc = -1;
    exp_q.push_back(e);
  endtask

  // Pops one expectation per DV or framing-error pulse
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (dv || ferr) begin
          if (exp_q.size() == 0) begin
            check8("unexpected_pulse", {6'd0, dv, ferr}, 8'h00);
          end else begin
            e = exp_q.pop_front();
            check1("frame_err", ferr, e.is_err);
            check1("rx_dv", dv, !e.is_err);
            check1("break", brk, e.brk);
            check8("rx_byte", rx_byte, e.byte_v);
            if (e.exp_cyc >= 0) check_range("dv_latency_cycle", cyc, e.exp_cyc - 1, e.exp_cyc + 1);
          end
        end else if (brk) begin
          check1("stray_break", brk, 1'b0);
        end
      end
    end
  endtask

  // Drives one 8N1 frame starting now, with no alignment to the clock
  task automatic send(input logic [7:0] b, input logic stop, input real bit_ns, input int idle_bits);
    rx = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #(bit_ns);
    end
    rx = stop;
    #(bit_ns);
    rx = 1'b1;
    if (idle_bits > 0) #(bit_ns * idle_bits);
  endtask

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int g;
    int hi_cyc;
    int lo_cyc;
    int low_run;
    int max_run;
    bit seen;

    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    rx       = 1'b1;
    fork monitor(); join_none

    repeat (3) @(negedge clk);
    check1("reset_active", active, 1'b0);
    check1("reset_dv", dv, 1'b0);
    check1("reset_ferr", ferr, 1'b0);
    check1("reset_break", brk, 1'b0);
    check8("reset_byte", rx_byte, 8'h00);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Byte with latency check: START 3 cycles after fall, DV one cycle after stop sample
    align();
    expect_dv(8'hA5, cyc + 3 + HALF + 9 * CPB + 1);
    send(8'hA5, 1'b1, BIT_NS, 2);

    // Two-cycle glitch on idle line
    align();
    g = cyc;
    rx = 1'b0;
    #(2 * CLK_NS);
    rx = 1'b1;
    hi_cyc = -1;
    lo_cyc = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (active && hi_cyc < 0) hi_cyc = cyc;
      if (!active && hi_cyc >= 0 && lo_cyc < 0) lo_cyc = cyc;
    end
    check1("glitch_active_pulsed", hi_cyc >= 0, 1'b1);
    check_range("glitch_active_clear_cycle", lo_cyc, g + 1, g + HALF + 4);
    check1("glitch_idle_after", active, 1'b0);

    // Stop bit low on non-zero data: framing error only, byte held
    align();
    expect_err(1'b0, 8'hA5);
    send(8'h3C, 1'b0, BIT_NS, 2);

    // Back-to-back frames with zero idle; watch the o_RX_Active gap
    align();
    expect_dv(8'h00, -1);
    expect_dv(8'hFF, -1);
    expect_dv(8'h55, -1);
    seen = 1'b0;
    low_run = 0;
    max_run = 0;
    fork
      begin
        send(8'h00, 1'b1, BIT_NS, 0);
        send(8'hFF, 1'b1, BIT_NS, 0);
        send(8'h55, 1'b1, BIT_NS, 2);
      end
      begin
        for (int i = 0; i < 2 * 10 * CPB + 4 * CPB; i++) begin
          @(negedge clk);
          if (active) begin
            seen = 1'b1;
            low_run = 0;
          end else if (seen) begin
            low_run++;
            if (low_run > max_run) max_run = low_run;
          end
        end
      end
    join
    check1("b2b_active_seen", seen, 1'b1);
    check_range("b2b_active_gap", max_run, 0, 3);

    // Line held low for 30 bit times: one error+break pulse, byte held
    align();
    expect_err(1'b1, 8'h55);
    rx = 1'b0;
    #(BIT_NS * 30);
    rx = 1'b1;
    #(BIT_NS * 2);
    align();
    expect_dv(8'h81, -1);
    send(8'h81, 1'b1, BIT_NS, 2);

    // Reset during data bit 4 of a frame discards it
    align();
    rx = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 4; i++) begin
      rx = (i % 2 == 0);
      #(BIT_NS);
    end
    rx = 1'b1;
    #(BIT_NS / 2.0);
    rst_n = 1'b0;
    #1;
    check1("midreset_active", active, 1'b0);
    check1("midreset_dv", dv, 1'b0);
    check1("midreset_ferr", ferr, 1'b0);
    check1("midreset_break", brk, 1'b0);
    check8("midreset_byte", rx_byte, 8'h00);
    #(BIT_NS);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    align();
    expect_dv(8'h7E, -1);
    send(8'h7E, 1'b1, BIT_NS, 2);

    // Baud skew of +/-4%
    align();
    expect_dv(8'hC3, -1);
    send(8'hC3, 1'b1, BIT_NS * 1.04, 2);
    align();
    expect_dv(8'hC3, -1);
    send(8'hC3, 1'b1, BIT_NS * 0.96, 2);

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    check8("pending_expectations", 8'(exp_q.size()), 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
